// File: rtl/l1_ahb_mtx_in_stage_pkg.sv
// Shared bus-matrix encodings (HTRANS/HBURST/HRESP) and the address-phase
// bundle that the matrix input stages and output arbiters pass around.
package l1_ahb_mtx_in_stage_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_e;

  typedef enum logic [2:0] {
    HBURST_SINGLE = 3'b000,
    HBURST_INCR   = 3'b001,
    HBURST_WRAP4  = 3'b010,
    HBURST_INCR4  = 3'b011,
    HBURST_WRAP8  = 3'b100,
    HBURST_INCR8  = 3'b101,
    HBURST_WRAP16 = 3'b110,
    HBURST_INCR16 = 3'b111
  } hburst_e;

  typedef enum logic [1:0] {
    HRESP_OKAY  = 2'b00,
    HRESP_ERROR = 2'b01
  } hresp_e;

  typedef struct packed {
    logic [31:0] addr;
    logic [1:0]  trans;
    logic        write;
    logic [2:0]  size;
    logic [2:0]  burst;
    logic [3:0]  prot;
    logic        lock;
  } addr_phase_t;

endpackage

// File: rtl/l1_ahb_mtx_in_stage_if.sv
// AHB slave-side port of one bus-matrix input: address phase from the master
// plus the ready/response returned to it.
interface l1_ahb_mtx_in_stage_if;
  logic        HSELS;
  logic [31:0] HADDRS;
  logic [1:0]  HTRANSS;
  logic        HWRITES;
  logic [2:0]  HSIZES;
  logic [2:0]  HBURSTS;
  logic [3:0]  HPROTS;
  logic        HMASTLOCKS;
  logic        HREADYS;
  logic        HREADYOUTS;
  logic [1:0]  HRESPS;

  modport slave (
    input  HSELS, HADDRS, HTRANSS, HWRITES, HSIZES, HBURSTS, HPROTS,
           HMASTLOCKS, HREADYS,
    output HREADYOUTS, HRESPS
  );

  modport master (
    output HSELS, HADDRS, HTRANSS, HWRITES, HSIZES, HBURSTS, HPROTS,
           HMASTLOCKS, HREADYS,
    input  HREADYOUTS, HRESPS
  );
endinterface

// File: rtl/l1_ahb_mtx_in_stage.sv
// Bus-matrix input stage: holds an address phase the output stage cannot take
// yet, and tracks this port's data phase to return ready/response to the master.
module l1_ahb_mtx_in_stage
  import l1_ahb_mtx_in_stage_pkg::*;
(
  input  logic                        HCLK,
  input  logic                        HRESETn,
  l1_ahb_mtx_in_stage_if.slave        ahb,
  input  logic                        active_dec,
  input  logic                        HREADYM,
  input  logic                        readyout_dec,
  input  logic [1:0]                  resp_dec,
  output logic [31:0]                 sel_addr,
  output logic [1:0]                  sel_trans,
  output logic                        sel_write,
  output logic [2:0]                  sel_size,
  output logic [2:0]                  sel_burst,
  output logic [3:0]                  sel_prot,
  output logic                        sel_lock,
  output logic                        trans_pend
);

  logic        sample_s;
  logic        accept;
  logic        reg_hold_q, reg_hold_d;
  logic        data_ph_q, data_ph_d;
  addr_phase_t live_ap, held_q, held_d, out_ap;

  // Only NONSEQ/SEQ (HTRANS[1]=1) are real transfers worth holding.
  assign sample_s = ahb.HSELS & ahb.HREADYS & ahb.HTRANSS[1];
  assign accept   = active_dec & HREADYM;

  assign live_ap = '{addr:  ahb.HADDRS,  trans: ahb.HTRANSS, write: ahb.HWRITES,
                     size:  ahb.HSIZES,  burst: ahb.HBURSTS, prot:  ahb.HPROTS,
                     lock:  ahb.HMASTLOCKS};

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    reg_hold_d = reg_hold_q;
    held_d     = held_q;
    data_ph_d  = data_ph_q;

    if (reg_hold_q && accept) begin
      reg_hold_d = 1'b0;
    end else if (sample_s && !accept) begin
      reg_hold_d = 1'b1;
      held_d     = live_ap;
    end

    if (accept && (reg_hold_q || sample_s)) begin
      data_ph_d = 1'b1;
    end else if (readyout_dec) begin
      data_ph_d = 1'b0;
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    // NOTE: non-blocking assignments so all state updates see pre-edge values.
    if (!HRESETn) begin
      reg_hold_q <= 1'b0;
      data_ph_q  <= 1'b0;
      held_q     <= '0;
    end else begin
      reg_hold_q <= reg_hold_d;
      data_ph_q  <= data_ph_d;
      held_q     <= held_d;
    end
  end

  always_comb begin
    out_ap = reg_hold_q ? held_q : live_ap;
    if (!reg_hold_q && !ahb.HSELS) begin
      out_ap.trans = HTRANS_IDLE;
    end
  end

  assign sel_addr  = out_ap.addr;
  assign sel_trans = out_ap.trans;
  assign sel_write = out_ap.write;
  assign sel_size  = out_ap.size;
  assign sel_burst = out_ap.burst;
  assign sel_prot  = out_ap.prot;
  assign sel_lock  = out_ap.lock;

  assign trans_pend = reg_hold_q | sample_s;

  // A held transfer stalls the master; otherwise the data phase owns ready.
  assign ahb.HREADYOUTS = reg_hold_q ? 1'b0 : (data_ph_q ? readyout_dec : 1'b1);
  assign ahb.HRESPS     = data_ph_q ? resp_dec : HRESP_OKAY;

endmodule

// File: tb/tb_l1_ahb_mtx_in_stage.sv
// Directed bench for the bus-matrix input stage: single, contended, burst,
// error, reset-during-hold and BUSY/IDLE pass-through scenarios.
module tb_l1_ahb_mtx_in_stage;
  import l1_ahb_mtx_in_stage_pkg::*;

  logic        HCLK = 1'b0;
  logic        HRESETn;
  logic        active_dec, HREADYM, readyout_dec;
  logic [1:0]  resp_dec;
  logic [31:0] sel_addr;
  logic [1:0]  sel_trans;
  logic        sel_write, sel_lock, trans_pend;
  logic [2:0]  sel_size, sel_burst;
  logic [3:0]  sel_prot;

  int checks   = 0;
  int failures = 0;

  l1_ahb_mtx_in_stage_if ahb ();

  l1_ahb_mtx_in_stage dut (
    .HCLK         (HCLK),
    .HRESETn      (HRESETn),
    .ahb          (ahb),
    .active_dec   (active_dec),
    .HREADYM      (HREADYM),
    .readyout_dec (readyout_dec),
    .resp_dec     (resp_dec),
    .sel_addr     (sel_addr),
    .sel_trans    (sel_trans),
    .sel_write    (sel_write),
    .sel_size     (sel_size),
    .sel_burst    (sel_burst),
    .sel_prot     (sel_prot),
    .sel_lock     (sel_lock),
    .trans_pend   (trans_pend)
  );

  always #5 HCLK = ~HCLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge; inputs change here.
  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  task automatic bus_idle();
    ahb.HSELS      = 1'b0;
    ahb.HADDRS     = 32'h0;
    ahb.HTRANSS    = HTRANS_IDLE;
    ahb.HWRITES    = 1'b0;
    ahb.HSIZES     = 3'b010;
    ahb.HBURSTS    = HBURST_SINGLE;
    ahb.HPROTS     = 4'h3;
    ahb.HMASTLOCKS = 1'b0;
    ahb.HREADYS    = 1'b1;
  endtask

  task automatic drive(input logic [31:0] addr, input logic [1:0] trans, input logic [2:0] burst);
    ahb.HSELS   = 1'b1;
    ahb.HADDRS  = addr;
    ahb.HTRANSS = trans;
    ahb.HBURSTS = burst;
    ahb.HREADYS = 1'b1;
  endtask

  initial begin
    HRESETn      = 1'b0;
    active_dec   = 1'b0;
    HREADYM      = 1'b1;
    readyout_dec = 1'b1;
    resp_dec     = HRESP_OKAY;
    bus_idle();

    // Reset state
    #2;
    check("rst_hreadyout", ahb.HREADYOUTS, 1);
    check("rst_hresp",     ahb.HRESPS, HRESP_OKAY);
    check("rst_trans_pend", trans_pend, 0);
    check("rst_reg_hold",  dut.reg_hold_q, 0);
    check("rst_sel_trans", sel_trans, HTRANS_IDLE);
    @(negedge HCLK);
    HRESETn = 1'b1;

    // Uncontended single transfer
    tick();
    active_dec = 1'b1;
    drive(32'h2000_0000, HTRANS_NONSEQ, HBURST_SINGLE);
    #1;
    check("single_sel_addr",  sel_addr, 32'h2000_0000);
    check("single_sel_trans", sel_trans, HTRANS_NONSEQ);
    check("single_pend",      trans_pend, 1);
    check("single_addr_rdy",  ahb.HREADYOUTS, 1);
    tick();
    bus_idle();
    readyout_dec = 1'b0;
    #1;
    check("single_no_hold",   dut.reg_hold_q, 0);
    check("single_rdy_low",   ahb.HREADYOUTS, 0);
    readyout_dec = 1'b1;
    #1;
    check("single_rdy_high",  ahb.HREADYOUTS, 1);
    tick();
    check("single_dph_done",  dut.data_ph_q, 0);

    // Contended transfer: not granted for three cycles, with a locked access
    active_dec = 1'b0;
    drive(32'h4000_0010, HTRANS_NONSEQ, HBURST_SINGLE);
    ahb.HMASTLOCKS = 1'b1;
    #1;
    check("cont_pend_sample", trans_pend, 1);
    check("cont_addr_sample", sel_addr, 32'h4000_0010);
    for (int i = 0; i < 3; i++) begin
      tick();
      ahb.HSELS      = 1'b0;
      ahb.HREADYS    = 1'b0;
      ahb.HADDRS     = 32'hDEAD_BEEF;
      ahb.HMASTLOCKS = 1'b0;
      if (i == 2) active_dec = 1'b1;
      #1;
      check($sformatf("cont_hold_%0d", i),  dut.reg_hold_q, 1);
      check($sformatf("cont_rdy_%0d", i),   ahb.HREADYOUTS, 0);
      check($sformatf("cont_addr_%0d", i),  sel_addr, 32'h4000_0010);
      check($sformatf("cont_trans_%0d", i), sel_trans, HTRANS_NONSEQ);
      check($sformatf("cont_pend_%0d", i),  trans_pend, 1);
      check($sformatf("cont_lock_%0d", i),  sel_lock, 1);
    end
    tick();
    ahb.HREADYS = 1'b1;
    #1;
    check("cont_hold_clr",   dut.reg_hold_q, 0);
    check("cont_dph_set",    dut.data_ph_q, 1);
    check("cont_rdy_dph",    ahb.HREADYOUTS, 1);
    check("cont_live_idle",  sel_trans, HTRANS_IDLE);
    check("cont_live_addr",  sel_addr, 32'hDEAD_BEEF);
    tick();
    bus_idle();

    // INCR4 back-to-back, always granted and ready
    for (int k = 0; k < 4; k++) begin
      drive(32'h1000_0000 + 32'(4 * k), (k == 0) ? HTRANS_NONSEQ : HTRANS_SEQ, HBURST_INCR4);
      #1;
      check($sformatf("incr4_addr_%0d", k), sel_addr, 32'h1000_0000 + 32'(4 * k));
      check($sformatf("incr4_burst_%0d", k), sel_burst, HBURST_INCR4);
      if (k > 0) check($sformatf("incr4_dph_%0d", k), dut.data_ph_q, 1);
      tick();
    end
    bus_idle();
    #1;
    check("incr4_dph_last",  dut.data_ph_q, 1);
    check("incr4_rdy_last",  ahb.HREADYOUTS, 1);
    check("incr4_no_hold",   dut.reg_hold_q, 0);
    tick();
    check("incr4_dph_end",   dut.data_ph_q, 0);

    // Two-cycle ERROR response
    drive(32'h3000_0000, HTRANS_NONSEQ, HBURST_SINGLE);
    tick();
    bus_idle();
    resp_dec     = HRESP_ERROR;
    readyout_dec = 1'b0;
    #1;
    check("err1_resp", ahb.HRESPS, HRESP_ERROR);
    check("err1_rdy",  ahb.HREADYOUTS, 0);
    tick();
    readyout_dec = 1'b1;
    #1;
    check("err2_resp", ahb.HRESPS, HRESP_ERROR);
    check("err2_rdy",  ahb.HREADYOUTS, 1);
    tick();
    resp_dec = HRESP_OKAY;
    #1;
    check("err_after_resp", ahb.HRESPS, HRESP_OKAY);
    check("err_after_dph",  dut.data_ph_q, 0);

    // Reset while a transfer is held
    active_dec = 1'b0;
    drive(32'h5000_0000, HTRANS_NONSEQ, HBURST_SINGLE);
    tick();
    ahb.HSELS   = 1'b0;
    ahb.HREADYS = 1'b0;
    #1;
    check("rsth_hold", dut.reg_hold_q, 1);
    check("rsth_rdy",  ahb.HREADYOUTS, 0);
    HRESETn = 1'b0;
    #1;
    check("rsth_rdy_async",  ahb.HREADYOUTS, 1);
    check("rsth_pend_async", trans_pend, 0);
    check("rsth_hold_async", dut.reg_hold_q, 0);
    @(negedge HCLK);
    HRESETn     = 1'b1;
    active_dec  = 1'b1;
    ahb.HREADYS = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("rsth_no_reissue_%0d", i), sel_trans, HTRANS_IDLE);
      check($sformatf("rsth_no_pend_%0d", i), trans_pend, 0);
    end

    // BUSY and IDLE pass through live and never hold
    active_dec = 1'b0;
    drive(32'h6000_0000, HTRANS_BUSY, HBURST_INCR);
    #1;
    check("busy_live",  sel_trans, HTRANS_BUSY);
    check("busy_pend",  trans_pend, 0);
    tick();
    check("busy_hold",  dut.reg_hold_q, 0);
    check("busy_rdy",   ahb.HREADYOUTS, 1);
    ahb.HTRANSS = HTRANS_IDLE;
    tick();
    check("idle_hold",  dut.reg_hold_q, 0);
    check("idle_rdy",   ahb.HREADYOUTS, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
